// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the integer register file: architectural
// register indices, stack-pointer reset value and the init/run state encoding.
package riscv_defs;

    // Hard-wired zero register
    localparam int unsigned ZERO_IDX = 0;

    // Default stack pointer index and its architectural reset value
    localparam int unsigned SP_IDX_DEF  = 2;
    localparam logic [31:0] SP_INIT_DEF = 32'hffff_fffc;

    // Register file control state
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

endpackage : riscv_defs

// File: rtl/regfile_init_ctrl.sv
// Post-reset initialisation sequencer for register_file_mp.
// Sweeps every register index once, supplying the architectural reset value,
// then switches to RUN and raises init_done for the rest of operation.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   init_done   - registered; high once the sweep has written index RLEN-1
//   init_we     - storage write strobe for the sweep (high throughout INIT)
//   init_idx    - register index written by the sweep this cycle
//   init_val    - value written by the sweep (SP_INIT at SP_IDX, else 0)
module regfile_init_ctrl
    import riscv_defs::*;
#(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     RLEN    = 32,
    parameter int unsigned     SP_IDX  = SP_IDX_DEF,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,
    output logic                    init_we,
    output logic [$clog2(RLEN)-1:0] init_idx,
    output logic [XLEN-1:0]         init_val
);

    localparam int unsigned AW = $clog2(RLEN);

    rf_state_e         state;
    rf_state_e         state_nxt;
    logic [AW-1:0]     init_cnt;
    logic [AW-1:0]     init_cnt_nxt;
    logic              init_done_nxt;

    // State register, sweep counter and done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            init_done <= init_done_nxt;
        end
    end

    // Next state: advance the sweep one index per edge, leave INIT after the last
    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        init_done_nxt = init_done;
        case (state)
            ST_INIT: begin
                init_cnt_nxt = init_cnt + AW'(1);
                if (init_cnt == AW'(RLEN - 1)) begin
                    state_nxt     = ST_RUN;
                    init_done_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Outputs: sweep write strobe, index and reset value
    always_comb begin
        init_we  = 1'b0;
        init_idx = init_cnt;
        init_val = '0;
        if (state == ST_INIT) begin
            init_we = 1'b1;
            if (init_cnt == AW'(SP_IDX)) begin
                init_val = SP_INIT;
            end
        end
    end

endmodule : regfile_init_ctrl

// File: rtl/register_file_mp.sv
// Multi-port integer register file: NREAD combinational read ports, two
// write lanes (lane B wins on a same-index collision), optional same-cycle
// write-to-read bypass and a hardware init sweep after reset.
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   init_done                   - high once all registers hold their reset value
//   we_a, rd_a, rd_val_a        - write lane A (enable, index, data)
//   we_b, rd_b, rd_val_b        - write lane B (enable, index, data)
//   rs_idx                      - packed read indices, port i at [i*AW +: AW]
//   rs_val                      - packed read data, port i at [i*XLEN +: XLEN]
module register_file_mp
    import riscv_defs::*;
#(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     RLEN    = 32,
    parameter int unsigned     NREAD   = 2,
    parameter int unsigned     BYPASS  = 1,
    parameter int unsigned     SP_IDX  = SP_IDX_DEF,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          init_done,
    input  logic                          we_a,
    input  logic [$clog2(RLEN)-1:0]       rd_a,
    input  logic [XLEN-1:0]               rd_val_a,
    input  logic                          we_b,
    input  logic [$clog2(RLEN)-1:0]       rd_b,
    input  logic [XLEN-1:0]               rd_val_b,
    input  logic [NREAD*$clog2(RLEN)-1:0] rs_idx,
    output logic [NREAD*XLEN-1:0]         rs_val
);

    localparam int unsigned AW = $clog2(RLEN);

    logic              init_we;
    logic [AW-1:0]     init_idx;
    logic [XLEN-1:0]   init_val;
    logic [XLEN-1:0]   data [RLEN];

    // Init sweep sequencer; init_done doubles as the RUN indicator
    regfile_init_ctrl #(
        .XLEN    (XLEN),
        .RLEN    (RLEN),
        .SP_IDX  (SP_IDX),
        .SP_INIT (SP_INIT)
    ) u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .init_val  (init_val)
    );

    // Storage: per-register write merge (sweep, else lane B, else lane A)
    for (genvar r = 0; r < RLEN; r++) begin : g_reg
        logic            wen;
        logic [XLEN-1:0] wval;
        logic [XLEN-1:0] q;

        always_comb begin
            wen  = 1'b0;
            wval = '0;
            if (init_we) begin
                if (init_idx == AW'(r)) begin
                    wen  = 1'b1;
                    wval = init_val;
                end
            end else if (r != ZERO_IDX) begin
                if (we_b && (rd_b == AW'(r))) begin
                    wen  = 1'b1;
                    wval = rd_val_b;
                end else if (we_a && (rd_a == AW'(r))) begin
                    wen  = 1'b1;
                    wval = rd_val_a;
                end
            end
        end

        // Storage holds its contents through reset; the sweep reinitialises it
        always_ff @(posedge clk) begin
            if (wen) begin
                q <= wval;
            end
        end

        assign data[r] = q;
    end

    // Read ports: zero during INIT and for x0, optional bypass with lane B priority
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] val;

        assign idx = rs_idx[i*AW +: AW];

        always_comb begin
            val = '0;
            if (init_done && (idx != AW'(ZERO_IDX))) begin
                if ((BYPASS != 0) && we_b && (rd_b == idx)) begin
                    val = rd_val_b;
                end else if ((BYPASS != 0) && we_a && (rd_a == idx)) begin
                    val = rd_val_a;
                end else begin
                    val = data[idx];
                end
            end
        end

        assign rs_val[i*XLEN +: XLEN] = val;
    end

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one bypassing and one non-bypassing
// instance driven from the same write lanes and read indices.
module tb_register_file_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RLEN = 32;
    localparam int unsigned AW   = 5;
    localparam logic [31:0] SPV  = 32'hffff_fffc;

    logic            clk;
    logic            rst_n;
    logic            we_a;
    logic [AW-1:0]   rd_a;
    logic [XLEN-1:0] rd_val_a;
    logic            we_b;
    logic [AW-1:0]   rd_b;
    logic [XLEN-1:0] rd_val_b;
    logic [2*AW-1:0] rs_idx;
    logic            init_done_byp;
    logic            init_done_nb;
    logic [2*XLEN-1:0] rs_val_byp;
    logic [2*XLEN-1:0] rs_val_nb;

    int checks   = 0;
    int failures = 0;

    register_file_mp #(
        .XLEN (XLEN), .RLEN (RLEN), .NREAD (2), .BYPASS (1)
    ) u_byp (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done_byp),
        .we_a      (we_a),
        .rd_a      (rd_a),
        .rd_val_a  (rd_val_a),
        .we_b      (we_b),
        .rd_b      (rd_b),
        .rd_val_b  (rd_val_b),
        .rs_idx    (rs_idx),
        .rs_val    (rs_val_byp)
    );

    register_file_mp #(
        .XLEN (XLEN), .RLEN (RLEN), .NREAD (2), .BYPASS (0)
    ) u_nb (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done_nb),
        .we_a      (we_a),
        .rd_a      (rd_a),
        .rd_val_a  (rd_val_a),
        .we_b      (we_b),
        .rd_b      (rd_b),
        .rd_val_b  (rd_val_b),
        .rs_idx    (rs_idx),
        .rs_val    (rs_val_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we_a;
        logic [4:0]    rd_a;
        logic [31:0]   va;
        logic          we_b;
        logic [4:0]    rd_b;
        logic [31:0]   vb;
        logic [4:0]    rs0;
        logic [4:0]    rs1;
        logic [31:0]   e0_byp;
        logic [31:0]   e1_byp;
        logic [31:0]   e0_nb;
        logic [31:0]   e1_nb;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_lanes();
        we_a = 1'b0; rd_a = '0; rd_val_a = '0;
        we_b = 1'b0; rd_b = '0; rd_val_b = '0;
    endtask

    // Count RLEN edges after reset release, checking init_done timing and zero reads
    task automatic sweep(input string tag);
        rs_idx = {5'd3, 5'd2};
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s edge%0d init_done byp", tag, e), 32'(init_done_byp), 32'(e == 32));
            check($sformatf("%s edge%0d init_done nb", tag, e), 32'(init_done_nb), 32'(e == 32));
            if (e < 32) begin
                check($sformatf("%s edge%0d init rd0", tag, e), rs_val_byp[31:0], 32'h0);
                check($sformatf("%s edge%0d init rd1", tag, e), rs_val_byp[63:32], 32'h0);
                check($sformatf("%s edge%0d init rd0 nb", tag, e), rs_val_nb[31:0], 32'h0);
            end
        end
        idle_lanes();
    endtask

    // Combinational read check on both instances
    task automatic read_check(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1);
        rs_idx = {a1, a0};
        #1;
        check({tag, " p0 byp"}, rs_val_byp[31:0],  e0);
        check({tag, " p1 byp"}, rs_val_byp[63:32], e1);
        check({tag, " p0 nb"},  rs_val_nb[31:0],   e0);
        check({tag, " p1 nb"},  rs_val_nb[63:32],  e1);
    endtask

    initial begin
        //            we_a rd_a va            we_b rd_b vb            rs0 rs1  e0_byp        e1_byp        e0_nb         e1_nb
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd2,  5'd5,  SPV,          32'h0,        SPV,          32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd3,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b1, 5'd5,  32'h1234,     1'b0, 5'd0, 32'h0,        5'd5,  5'd2,  32'h1234,     SPV,          32'h0,        SPV};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd5,  5'd0,  32'h1234,     32'h0,        32'h1234,     32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'hAAAA,     1'b1, 5'd7, 32'hBBBB,     5'd7,  5'd5,  32'hBBBB,     32'h1234,     32'h0,        32'h1234};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  32'hBBBB,     32'hBBBB,     32'hBBBB,     32'hBBBB};
        vecs[6]  = '{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  32'h0,        32'hBBBB,     32'h0,        32'hBBBB};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd0,  5'd7,  32'h0,        32'hBBBB,     32'h0,        32'hBBBB};
        vecs[8]  = '{1'b1, 5'd10, 32'h66,       1'b1, 5'd9, 32'h55,       5'd9,  5'd10, 32'h55,       32'h66,       32'h0,        32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd9,  5'd10, 32'h55,       32'h66,       32'h55,       32'h66};
        vecs[10] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 5'd1, 32'h1,        5'd31, 5'd1,  32'hDEADBEEF, 32'h1,        32'h0,        32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd31, 5'd1,  32'hDEADBEEF, 32'h1,        32'hDEADBEEF, 32'h1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h123,      5'd0,  5'd9,  32'h0,        32'h55,       32'h0,        32'h55};

        // Reset with writes attempted on both lanes
        rst_n  = 1'b0;
        rs_idx = {5'd3, 5'd2};
        we_a = 1'b1; rd_a = 5'd2; rd_val_a = 32'h99;
        we_b = 1'b1; rd_b = 5'd3; rd_val_b = 32'h77;
        repeat (3) @(posedge clk);
        #1;
        check("reset init_done byp", 32'(init_done_byp), 32'h0);
        check("reset init_done nb",  32'(init_done_nb),  32'h0);
        check("reset rd byp", rs_val_byp[31:0], 32'h0);

        // First sweep; lane writes during INIT must be ignored
        @(negedge clk);
        rst_n = 1'b1;
        sweep("init1");

        // Table-driven RUN vectors: check before the edge, the edge commits writes
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            we_a = vecs[i].we_a; rd_a = vecs[i].rd_a; rd_val_a = vecs[i].va;
            we_b = vecs[i].we_b; rd_b = vecs[i].rd_b; rd_val_b = vecs[i].vb;
            rs_idx = {vecs[i].rs1, vecs[i].rs0};
            #2;
            check($sformatf("vec%0d p0 byp", i), rs_val_byp[31:0],  vecs[i].e0_byp);
            check($sformatf("vec%0d p1 byp", i), rs_val_byp[63:32], vecs[i].e1_byp);
            check($sformatf("vec%0d p0 nb", i),  rs_val_nb[31:0],   vecs[i].e0_nb);
            check($sformatf("vec%0d p1 nb", i),  rs_val_nb[63:32],  vecs[i].e1_nb);
        end
        @(negedge clk);
        idle_lanes();

        // Mid-cycle reset in RUN: init_done drops at once, storage re-swept
        #2;
        rst_n = 1'b0;
        rs_idx = {5'd2, 5'd9};
        #1;
        check("run reset init_done byp", 32'(init_done_byp), 32'h0);
        check("run reset init_done nb",  32'(init_done_nb),  32'h0);
        check("run reset rd x9 byp", rs_val_byp[31:0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("init2");
        @(negedge clk);
        read_check("after init2 x9/x2", 5'd9, 5'd2, 32'h0, SPV);
        read_check("after init2 x31/x7", 5'd31, 5'd7, 32'h0, 32'h0);

        // Reset part-way through a sweep restarts it from index 0
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-init reset init_done", 32'(init_done_byp), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("init3");
        @(negedge clk);
        read_check("after init3 x2/x3", 5'd2, 5'd3, SPV, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file_mp

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the integer datapath. It provides NREAD combinational read ports and two synchronous write ports, with optional same-cycle write-to-read bypass. After reset it runs a hardware initialisation sweep that loads every register with its architectural reset value: x0 and all other registers get 0, and the stack pointer gets SP_INIT. It sits between decode (read indices) and writeback (two retire lanes), and gates pipeline start through `init_done`.

## Interface
- XLEN, 32, register width in bits
- RLEN, 32, number of registers; power of two, ≥ 4; AW = $clog2(RLEN)
- NREAD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = read ports see same-cycle writes; 0 = read storage only
- SP_IDX, 2, index of stack pointer
- SP_INIT, 32'hfffffffc, stack pointer reset value (XLEN bits)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once the init sweep completes; reset value 0
- we_a  in  1  write enable, lane A
- rd_a  in  AW  destination index, lane A
- rd_val_a  in  XLEN  write data, lane A
- we_b  in  1  write enable, lane B
- rd_b  in  AW  destination index, lane B
- rd_val_b  in  XLEN  write data, lane B
- rs_idx  in  NREAD*AW  packed read indices; port i at [i*AW +: AW]
- rs_val  out  NREAD*XLEN  packed read data; port i at [i*XLEN +: XLEN]

## Operation
- Two states, INIT and RUN, held in a 1-bit state register plus an AW-bit init counter `init_cnt`.
- rst_n low: state = INIT, init_cnt = 0, init_done = 0. Storage is not cleared by reset itself.
- INIT, each clk edge:
  - data[init_cnt] ← (init_cnt == SP_IDX) ? SP_INIT : 0
  - init_cnt increments.
  - On the edge that writes index RLEN-1, state → RUN and init_done → 1.
- INIT: we_a and we_b are ignored. Every rs_val port returns 0.
- RUN, each clk edge:
  - Lane A writes if we_a && rd_a != 0.
  - Lane B writes if we_b && rd_b != 0.
  - Both lanes enabled on the same nonzero index: lane B's value is stored and lane A's is dropped.
- Register 0 always reads 0, in RUN and under bypass, regardless of any write attempt.
- Reads in RUN are combinational. With BYPASS = 1, port i returns:
  - 0 if rs_idx_i == 0;
  - else rd_val_b if we_b && rd_b == rs_idx_i;
  - else rd_val_a if we_a && rd_a == rs_idx_i;
  - else data[rs_idx_i].
- With BYPASS = 0, port i returns 0 for index 0, else data[rs_idx_i].
- Reset asserted mid-INIT or mid-RUN: returns to INIT with init_cnt = 0 and restarts the full sweep. A write on the edge where reset asserts is lost.

## Timing
- The init sweep takes exactly RLEN rising edges after rst_n deasserts. init_done is registered and is high from the RLEN-th edge onward.
- Write latency: 1 cycle. A value is visible from storage in the cycle after the write edge.
- Bypass: the value is visible in the same cycle as we_x.
- No back-pressure. Writeback must hold off until init_done = 1; lane inputs are don't-care before then.
- Read path is purely combinational from rs_idx, state and the write lanes. It has no registered output.

## Structure
- Shared package/header `riscv_defs`: ZERO_IDX = 0, SP_IDX default, SP_INIT default, and the state encoding (INIT = 0, RUN = 1).
- Sub-module `regfile_init_ctrl` holds the state, the init_cnt counter and init_done. It outputs `init_we`, `init_idx` and `init_val` to the storage write mux.
- Storage array, write-lane merge, and NREAD read/bypass muxes are built with a generate loop in the top module.

## Test plan
- Reset release with RLEN = 32: init_done = 0 for edges 1–31 and goes high on edge 32; all reads return 0 during INIT. In RUN, read x2 → 32'hfffffffc, x5 → 0.
- RUN, we_a = 1, rd_a = 5, rd_val_a = 32'h1234 with rs_idx port0 = 5 in the same cycle:
  - BYPASS = 1 → rs_val0 = 32'h1234 in that cycle.
  - BYPASS = 0 → old value 0 in that cycle, then 32'h1234 next cycle.
- Both lanes write rd = 7 (A = 32'hAAAA, B = 32'hBBBB) → bypass and subsequent reads return 32'hBBBB.
- we_a = 1, rd_a = 0, rd_val_a = 32'hFFFF → port reading x0 returns 0 in the same and next cycle.
- Write x9 = 32'h55 in RUN, then pulse rst_n low mid-cycle → init_done drops immediately. After RLEN edges, x9 reads 0 and x2 reads SP_INIT.
- During INIT, we_b = 1, rd_b = 3, rd_val_b = 32'h77 → ignored; x3 reads 0 after init_done.
